// File: rtl/display_source_scheduler.sv
// Round-robin scheduler that time-shares the 16-bit seven-segment display value
// among up to four sources, with a manual pin override.
module display_source_scheduler #(
    parameter int unsigned HOLD_CYCLES = 50000000,
    parameter int unsigned CNT_W       = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  src_valid,
    input  logic [63:0] src_data,
    input  logic        pin_en,
    input  logic [1:0]  pin_sel,
    output logic [15:0] disp_value,
    output logic [1:0]  disp_src,
    output logic        disp_blank,
    output logic        disp_update
);

    typedef enum logic [1:0] {IDLE, SHOW, PIN} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [15:0]      disp_value_q, disp_value_d;
    logic [1:0]       disp_src_q, disp_src_d;
    logic             disp_blank_q, disp_blank_d;
    logic             disp_update_q, disp_update_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;

    // First valid source after base, wrapping so base itself is tried last.
    function automatic logic [2:0] next_valid(input logic [1:0] base, input logic [3:0] v);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (v[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [15:0] word(input logic [1:0] i, input logic [63:0] d);
        logic [15:0] w;
        case (i)
            2'd0:    w = d[15:0];
            2'd1:    w = d[31:16];
            2'd2:    w = d[47:32];
            default: w = d[63:48];
        endcase
        return w;
    endfunction

    logic [2:0] nv_idle, nv_cur;
    assign nv_idle = next_valid(rr_ptr_q, src_valid);
    assign nv_cur  = next_valid(disp_src_q, src_valid);

    always_comb begin
        state_d       = state_q;
        disp_value_d  = disp_value_q;
        disp_src_d    = disp_src_q;
        disp_blank_d  = disp_blank_q;
        disp_update_d = 1'b0;
        hold_cnt_d    = hold_cnt_q;
        rr_ptr_d      = rr_ptr_q;

        case (state_q)
            IDLE: begin
                disp_blank_d = 1'b1;
                disp_value_d = 16'h0000;
                hold_cnt_d   = '0;
                if (pin_en) begin
                    state_d       = PIN;
                    disp_src_d    = pin_sel;
                    disp_value_d  = word(pin_sel, src_data);
                    disp_blank_d  = 1'b0;
                    disp_update_d = 1'b1;
                end else if (nv_idle[2]) begin
                    state_d       = SHOW;
                    disp_src_d    = nv_idle[1:0];
                    disp_value_d  = word(nv_idle[1:0], src_data);
                    disp_blank_d  = 1'b0;
                    disp_update_d = 1'b1;
                end
            end
            SHOW: begin
                disp_blank_d = 1'b0;
                hold_cnt_d   = hold_cnt_q + CNT_W'(1);
                disp_value_d = word(disp_src_q, src_data);
                if (pin_en) begin
                    state_d       = PIN;
                    disp_src_d    = pin_sel;
                    disp_value_d  = word(pin_sel, src_data);
                    hold_cnt_d    = '0;
                    disp_update_d = (pin_sel != disp_src_q);
                end else if (!src_valid[disp_src_q]) begin
                    hold_cnt_d = '0;
                    if (nv_cur[2]) begin
                        disp_src_d    = nv_cur[1:0];
                        disp_value_d  = word(nv_cur[1:0], src_data);
                        disp_update_d = 1'b1;
                    end else begin
                        state_d      = IDLE;
                        disp_value_d = 16'h0000;
                        disp_blank_d = 1'b1;
                    end
                end else if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d    = '0;
                    disp_src_d    = nv_cur[1:0];
                    disp_value_d  = word(nv_cur[1:0], src_data);
                    disp_update_d = (nv_cur[1:0] != disp_src_q);
                end
            end
            PIN: begin
                disp_blank_d = 1'b0;
                hold_cnt_d   = '0;
                if (pin_en) begin
                    disp_src_d    = pin_sel;
                    disp_value_d  = word(pin_sel, src_data);
                    disp_update_d = (pin_sel != disp_src_q);
                end else if (src_valid[disp_src_q]) begin
                    state_d      = SHOW;
                    disp_value_d = word(disp_src_q, src_data);
                end else if (nv_cur[2]) begin
                    state_d       = SHOW;
                    disp_src_d    = nv_cur[1:0];
                    disp_value_d  = word(nv_cur[1:0], src_data);
                    disp_update_d = 1'b1;
                end else begin
                    state_d      = IDLE;
                    disp_value_d = 16'h0000;
                    disp_blank_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Round-robin pointer follows the shown source; untouched while idle.
        if (state_d != IDLE) rr_ptr_d = disp_src_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            disp_value_q  <= 16'h0000;
            disp_src_q    <= 2'd0;
            disp_blank_q  <= 1'b1;
            disp_update_q <= 1'b0;
            hold_cnt_q    <= '0;
            rr_ptr_q      <= 2'd3;
        end else begin
            state_q       <= state_d;
            disp_value_q  <= disp_value_d;
            disp_src_q    <= disp_src_d;
            disp_blank_q  <= disp_blank_d;
            disp_update_q <= disp_update_d;
            hold_cnt_q    <= hold_cnt_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign disp_value  = disp_value_q;
    assign disp_src    = disp_src_q;
    assign disp_blank  = disp_blank_q;
    assign disp_update = disp_update_q;

endmodule

// File: tb/tb_display_source_scheduler.sv
// Directed bench for display_source_scheduler with a short hold time of 4 cycles.
module tb_display_source_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  src_valid = 4'h0;
    logic [63:0] src_data = 64'h0;
    logic        pin_en = 1'b0;
    logic [1:0]  pin_sel = 2'd0;
    logic [15:0] disp_value;
    logic [1:0]  disp_src;
    logic        disp_blank;
    logic        disp_update;

    int checks = 0;
    int errors = 0;

    // {blank, update, src, value}
    logic [19:0] got;
    assign got = {disp_blank, disp_update, disp_src, disp_value};

    always #5 clk = ~clk;

    display_source_scheduler #(.HOLD_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data),
        .pin_en(pin_en), .pin_sel(pin_sel), .disp_value(disp_value),
        .disp_src(disp_src), .disp_blank(disp_blank), .disp_update(disp_update)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset(input logic [3:0] v, input logic [63:0] d);
        rst_n = 1'b0; pin_en = 1'b0; pin_sel = 2'd0;
        src_valid = v; src_data = d;
        tick(); tick();
    endtask

    task automatic test_reset();
        logic [19:0] exp;
        rst_n = 1'b0; src_valid = 4'hF;
        src_data = 64'h4444_3333_2222_1111;
        for (int c = 0; c < 3; c++) begin
            tick();
            exp = {1'b1, 1'b0, 2'd0, 16'h0000};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL reset c%0d got %h exp %h", c, got, exp);
            end
        end
        rst_n = 1'b1;
        tick();
        exp = {1'b0, 1'b1, 2'd0, 16'h1111};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL reset_release got %h exp %h", got, exp);
        end
    endtask

    task automatic test_rotation();
        logic [19:0] exp;
        logic [15:0] ev;
        logic [1:0]  es;
        hold_reset(4'b1011, 64'h4444_3333_2222_1111);
        rst_n = 1'b1;
        tick();
        for (int c = 0; c < 13; c++) begin
            if (c < 4)       begin ev = 16'h1111; es = 2'd0; end
            else if (c < 8)  begin ev = 16'h2222; es = 2'd1; end
            else if (c < 12) begin ev = 16'h4444; es = 2'd3; end
            else             begin ev = 16'h1111; es = 2'd0; end
            exp = {1'b0, (c % 4) == 0, es, ev};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL rotation c%0d got %h exp %h", c, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_single();
        logic [19:0] exp;
        hold_reset(4'b0100, 64'h0000_ABCD_0000_0000);
        rst_n = 1'b1;
        tick();
        exp = {1'b0, 1'b1, 2'd2, 16'hABCD};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL single_enter got %h exp %h", got, exp);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            exp = {1'b0, 1'b0, 2'd2, 16'hABCD};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL single_hold c%0d got %h exp %h", c, got, exp);
            end
        end
        src_data = 64'h0000_1234_0000_0000;
        tick();
        exp = {1'b0, 1'b0, 2'd2, 16'h1234};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL single_live got %h exp %h", got, exp);
        end
    endtask

    task automatic test_invalidation();
        logic [19:0] exp;
        hold_reset(4'b1011, 64'h4444_3333_2222_1111);
        rst_n = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) tick();
        exp = {1'b0, 1'b0, 2'd1, 16'h2222};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL inv_pre got %h exp %h", got, exp);
        end
        src_valid = 4'b1001;
        tick();
        exp = {1'b0, 1'b1, 2'd3, 16'h4444};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL inv_switch got %h exp %h", got, exp);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            exp = {1'b0, 1'b0, 2'd3, 16'h4444};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL inv_hold c%0d got %h exp %h", c, got, exp);
            end
        end
        tick();
        exp = {1'b0, 1'b1, 2'd0, 16'h1111};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL inv_next got %h exp %h", got, exp);
        end
        src_valid = 4'b0000;
        tick();
        exp = {1'b1, 1'b0, 2'd0, 16'h0000};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL inv_idle got %h exp %h", got, exp);
        end
    endtask

    task automatic test_pin();
        logic [19:0] exp;
        hold_reset(4'b1011, 64'h4444_5A5A_2222_1111);
        rst_n = 1'b1;
        tick();
        pin_en = 1'b1; pin_sel = 2'd2;
        tick();
        exp = {1'b0, 1'b1, 2'd2, 16'h5A5A};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL pin_enter got %h exp %h", got, exp);
        end
        for (int c = 0; c < 14; c++) begin
            tick();
            exp = {1'b0, 1'b0, 2'd2, 16'h5A5A};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL pin_hold c%0d got %h exp %h", c, got, exp);
            end
        end
        pin_sel = 2'd0;
        tick();
        exp = {1'b0, 1'b1, 2'd0, 16'h1111};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL pin_resel got %h exp %h", got, exp);
        end
        tick();
        exp = {1'b0, 1'b0, 2'd0, 16'h1111};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL pin_resel_hold got %h exp %h", got, exp);
        end
        pin_en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            exp = {1'b0, 1'b0, 2'd0, 16'h1111};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL pin_exit c%0d got %h exp %h", c, got, exp);
            end
        end
        tick();
        exp = {1'b0, 1'b1, 2'd1, 16'h2222};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL pin_resume got %h exp %h", got, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] exp;
        hold_reset(4'b1011, 64'h4444_3333_2222_1111);
        rst_n = 1'b1;
        tick();
        for (int c = 0; c < 10; c++) tick();
        exp = {1'b0, 1'b0, 2'd3, 16'h4444};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL mid_pre got %h exp %h", got, exp);
        end
        rst_n = 1'b0; src_valid = 4'b1010;
        tick();
        exp = {1'b1, 1'b0, 2'd0, 16'h0000};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL mid_reset got %h exp %h", got, exp);
        end
        tick();
        rst_n = 1'b1;
        tick();
        exp = {1'b0, 1'b1, 2'd1, 16'h2222};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL mid_release got %h exp %h", got, exp);
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_single();
        test_invalidation();
        test_pin();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_source_scheduler.md
Name: display_source_scheduler

Overview:
Time-shares the 16-bit hex value of the 4-digit seven-segment display between up to four requesters (e.g. accumulator, PC, memory data, debug word). Rotates round-robin among valid sources, showing each for a fixed hold time. Supports a manual "pin" override that freezes the display on one selected source. Output drives the value input of the seven-segment display driver; disp_src can be shown on LEDs.

Parameters:
HOLD_CYCLES, 50000000, clk cycles each source stays displayed before rotation (1 s at 50 MHz); legal range 1..2^CNT_W-1
CNT_W, 26, hold counter width; must satisfy 2^CNT_W > HOLD_CYCLES

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
src_valid  input  4  bit i = source i has data to show
src_data  input  64  packed source values; source i at [16*i+15:16*i]
pin_en  input  1  1 = override rotation, show source pin_sel
pin_sel  input  2  source index shown while pin_en=1
disp_value  output  16  registered value for the display driver
disp_src  output  2  index of source currently shown
disp_blank  output  1  1 = nothing to show; display driver blanks all anodes
disp_update  output  1  one-cycle pulse on the cycle disp_src changes or display leaves IDLE

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, disp_value=16'h0000, disp_src=0, disp_blank=1, disp_update=0, hold_cnt=0, rr_ptr=3 (first search starts at source 0).
- All outputs registered. disp_value tracks src_data[disp_src] live with 1-cycle latency in SHOW and PIN.
- Next-valid search: first i in order rr_ptr+1, rr_ptr+2, ... (mod 4) with src_valid[i]=1, including rr_ptr itself last.
- States:
  - IDLE: disp_blank=1, disp_value held at 0. If pin_en -> PIN. Else if any src_valid -> SHOW with disp_src=next-valid, hold_cnt=0, disp_update=1.
  - SHOW: disp_blank=0. hold_cnt increments each cycle.
    - When hold_cnt reaches HOLD_CYCLES-1, select next-valid from rr_ptr=disp_src and reset hold_cnt=0. disp_update=1 only if the index changes. If the current source is the only valid one, it stays and restarts with no pulse.
    - If src_valid[disp_src] drops, switch next cycle to next-valid with hold_cnt=0 and disp_update=1. If no source is valid -> IDLE with disp_value=0, disp_blank=1, and no pulse.
    - pin_en=1 has priority over expiry and invalidation -> PIN.
  - PIN: disp_src=pin_sel, disp_value=src_data[pin_sel] regardless of src_valid, disp_blank=0, hold_cnt held 0. disp_update pulses on entry if the index changes and on any pin_sel change. On pin_en=0, if src_valid[disp_src]=1 go to SHOW keeping disp_src with a fresh hold window. Otherwise follow the invalidation rule above.
- Simultaneous expiry and invalidation of the current source: treat as invalidation (single switch, single pulse).
- HOLD_CYCLES=1: rotate every cycle among valid sources.
- hold_cnt never wraps. It is compared by equality and cleared on every switch.
- Reset mid-operation overrides everything in the same cycle. Outputs return to reset values on the next posedge after rst_n sampled low.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with src_valid=4'hF -> disp_blank=1, disp_value=0000, disp_src=0, disp_update=0. Release -> 1 cycle later SHOW on src 0 with disp_update=1.
- Rotation (HOLD_CYCLES=4): valid=4'b1011, data 1111/2222/3333/4444 -> disp_value 1111 x4 cycles, 2222 x4, 4444 x4, 1111 again. disp_update pulses at each change.
- Single source: valid=4'b0100, data=ABCD -> disp_value=ABCD constant, disp_update pulses only once on leaving IDLE. Change data to 1234 -> disp_value=1234 one cycle later.
- Invalidation: showing src 1 at hold_cnt=1, drop valid[1] -> next cycle src 3 with hold restarted. Drop all valid -> IDLE, disp_blank=1, disp_value=0000.
- Pin: pin_en=1, pin_sel=2 with valid[2]=0 and data 5A5A -> disp_src=2, disp_value=5A5A held beyond 3xHOLD_CYCLES. pin_sel 2->0 gives one disp_update pulse. pin_en=0 -> rotation resumes from src 0.
- Reset mid-rotation at hold_cnt=2 on src 3 -> all outputs at reset values. After release, first source shown is the lowest-index valid source.
